// File: rtl/odd_seq_checker_if.sv
// Sample/status bundle between the odd-number stream source and its checker.
// The source (or bench) takes master; the checker takes slave.
interface odd_seq_checker_if #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 16
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] expected;

    modport master (
        output in_valid, in_data,
        input  locked, err_pulse, err_count, expected
    );

    modport slave (
        input  in_valid, in_data,
        output locked, err_pulse, err_count, expected
    );
endinterface

// File: rtl/odd_seq_checker.sv
// Lock-and-track checker for the +STEP odd-number stream; counts breaks in
// the sequence once locked, freewheeling the prediction over corrupt samples.
module odd_seq_checker #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 2,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    odd_seq_checker_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK4  = 4'(LOCK_CNT);
    localparam logic [3:0]       LOSS4  = 4'(LOSS_CNT);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state, state_n;
    logic [WIDTH-1:0] last, last_n;
    logic [3:0]       run, run_n;
    logic [3:0]       miss, miss_n;
    logic [ERR_W-1:0] cnt_q, cnt_n;
    logic             pulse_q, pulse_n;
    logic             locked_q;
    logic [WIDTH-1:0] pred;
    logic             match;

    assign pred  = last + STEP_W;
    assign match = (bus.in_data == pred);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            last     <= '0;
            run      <= '0;
            miss     <= '0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_n;
            last     <= last_n;
            run      <= run_n;
            miss     <= miss_n;
            cnt_q    <= cnt_n;
            pulse_q  <= pulse_n;
            locked_q <= (state_n == LOCKED);
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        run_n   = run;
        miss_n  = miss;
        cnt_n   = cnt_q;
        pulse_n = 1'b0;
        if (bus.in_valid) begin
            unique case (state)
                SEARCH: begin
                    if (bus.in_data[0]) begin
                        last_n  = bus.in_data;
                        run_n   = 4'd1;
                        state_n = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (match) begin
                        last_n = bus.in_data;
                        run_n  = run + 4'd1;
                        if (run + 4'd1 == LOCK4) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else if (bus.in_data[0]) begin
                        last_n = bus.in_data;
                        run_n  = 4'd1;
                    end else begin
                        state_n = SEARCH;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        last_n = bus.in_data;
                        miss_n = '0;
                    end else begin
                        pulse_n = 1'b1;
                        if (cnt_q != '1)
                            cnt_n = cnt_q + ERR_W'(1);
                        // advance on the prediction so one bad sample costs one error
                        last_n = pred;
                        miss_n = miss + 4'd1;
                        if (miss + 4'd1 == LOSS4) begin
                            state_n = SEARCH;
                            run_n   = '0;
                            miss_n  = '0;
                        end
                    end
                end
                default: state_n = SEARCH;
            endcase
        end
    end

    always_comb begin
        bus.locked    = locked_q;
        bus.err_pulse = pulse_q;
        bus.err_count = cnt_q;
        bus.expected  = pred;
    end

endmodule

// File: tb/tb_odd_seq_checker.sv
// Scoreboard bench for odd_seq_checker: directed stream scenarios followed by
// randomized streams with gaps, glitches, bursts and resets.
module tb_odd_seq_checker;

    localparam int WIDTH    = 8;
    localparam int STEP     = 2;
    localparam int LOCK_CNT = 3;
    localparam int LOSS_CNT = 2;
    localparam int ERR_W    = 4;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;
    localparam int MODN     = 1 << WIDTH;

    logic clk;
    logic reset;

    odd_seq_checker_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

    odd_seq_checker #(
        .WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int locked;
        int pulse;
        int cnt;
        int expd;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference: tracks whether we are hunting, building a run, or tracking
    int m_phase;   // 0 hunting, 1 building run, 2 tracking
    int m_last;
    int m_run;
    int m_miss;
    int m_err;
    int m_pulse;

    task automatic model_step(input bit r, input bit v, input int d);
        exp_t e;
        int   nxt;
        m_pulse = 0;
        if (r) begin
            m_phase = 0; m_last = 0; m_run = 0; m_miss = 0; m_err = 0;
        end else if (v) begin
            nxt = (m_last + STEP) % MODN;
            if (m_phase == 0) begin
                if (d % 2 == 1) begin
                    m_last = d; m_run = 1; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (d == nxt) begin
                    m_last = d; m_run = m_run + 1;
                    if (m_run == LOCK_CNT) begin
                        m_phase = 2; m_miss = 0;
                    end
                end else if (d % 2 == 1) begin
                    m_last = d; m_run = 1;
                end else begin
                    m_phase = 0;
                end
            end else begin
                if (d == nxt) begin
                    m_last = d; m_miss = 0;
                end else begin
                    m_pulse = 1;
                    m_err   = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                    m_last  = nxt;
                    m_miss  = m_miss + 1;
                    if (m_miss == LOSS_CNT) begin
                        m_phase = 0; m_run = 0; m_miss = 0;
                    end
                end
            end
        end
        e.locked = (m_phase == 2) ? 1 : 0;
        e.pulse  = m_pulse;
        e.cnt    = m_err;
        e.expd   = (m_last + STEP) % MODN;
        q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit v, input int d);
        @(posedge clk);
        #2;
        reset        = r;
        bus.in_valid = v;
        bus.in_data  = WIDTH'(d);
        model_step(r, v, d);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_cmp = n_cmp + 1;
        if (act != req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: each cycle the DUT presents status for the sample taken at the last edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("locked",    int'(bus.locked),    e.locked);
                chk("err_pulse", int'(bus.err_pulse), e.pulse);
                chk("err_count", int'(bus.err_count), e.cnt);
                chk("expected",  int'(bus.expected),  e.expd);
            end
        end
    end

    task automatic feed_run(input int first, input int n);
        int v;
        v = first;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, v);
            v = (v + STEP) % MODN;
        end
    endtask

    initial begin
        int src;
        int sel;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b1, 7);
        drive(1'b0, 1'b0, 0);

        // acquisition, then continuous run across the 255 -> 1 wrap
        feed_run(1, 130);
        // glitch while locked: predicted 21, then 21,40,25,27
        drive(1'b1, 1'b0, 0);
        feed_run(1, 10);
        drive(1'b0, 1'b1, 21);
        drive(1'b0, 1'b1, 40);
        drive(1'b0, 1'b1, 25);
        drive(1'b0, 1'b1, 27);
        // lock loss and re-lock
        drive(1'b1, 1'b0, 0);
        feed_run(1, 4);
        drive(1'b0, 1'b1, 100);
        drive(1'b0, 1'b1, 100);
        feed_run(7, 4);
        // even rejection and acquire restart
        drive(1'b1, 1'b0, 0);
        drive(1'b0, 1'b1, 0);
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b1, 5);
        drive(1'b0, 1'b1, 9);
        drive(1'b0, 1'b1, 11);
        drive(1'b0, 1'b1, 13);
        drive(1'b0, 1'b0, 0);
        // gaps while locked, then reset colliding with a valid sample
        drive(1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1 + 2 * i);
            drive(1'b0, 1'b0, 99);
        end
        drive(1'b1, 1'b1, 3);
        drive(1'b0, 1'b0, 0);
        // saturation: long locked stretch with isolated corruptions
        feed_run(1, 5);
        src = 11;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 0);
            src = (src + STEP) % MODN;
            drive(1'b0, 1'b1, src);
            src = (src + STEP) % MODN;
        end

        // randomized stream
        drive(1'b1, 1'b0, 0);
        src = 1;
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                drive(1'b1, ($urandom_range(0, 1) == 1), src);
            end else if (sel < 12) begin
                drive(1'b0, 1'b0, int'($urandom_range(0, MODN - 1)));
            end else if (sel < 17) begin
                drive(1'b0, 1'b1, int'($urandom_range(0, MODN - 1)));
            end else if (sel < 19) begin
                for (int k = 0; k < 3; k++)
                    drive(1'b0, 1'b1, int'($urandom_range(0, MODN - 1)));
            end else if (sel < 20) begin
                src = int'($urandom_range(0, MODN - 1)) | 1;
                drive(1'b0, 1'b1, src);
                src = (src + STEP) % MODN;
            end else begin
                drive(1'b0, 1'b1, src);
                src = (src + STEP) % MODN;
            end
        end
        drive(1'b0, 1'b0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(posedge clk);
            #3;
        end
        n_cmp = n_cmp + 1;
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: got %0d pending, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/odd_seq_checker.md
# odd_seq_checker

Receive-side checker for the odd-number counter stream (1, 3, 5, … 255, 1, …). It samples a data bus qualified by a valid strobe and acquires lock on the arithmetic progression. Once locked, it flags every sample that breaks the +STEP sequence and counts errors. It sits downstream of the odd counter, either on-chip or in the bench, as the self-check for that stream.

## Interface
- WIDTH, 8, data width; all sequence arithmetic is modulo 2^WIDTH
- STEP, 2, expected increment between consecutive valid samples
- LOCK_CNT, 3, consecutive in-sequence samples (first one included) needed to declare lock; legal range 2..15
- LOSS_CNT, 2, consecutive mismatches while locked that drop lock; legal range 1..15
- ERR_W, 16, width of err_count
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_data is a sample this cycle
- in_data  in  WIDTH  sample value
- locked  out  1  high while in LOCKED state
- err_pulse  out  1  one-cycle pulse per mismatching sample while locked
- err_count  out  ERR_W  total mismatches while locked; saturates at all-ones
- expected  out  WIDTH  next predicted value (last + STEP); meaningful only when locked or acquiring

## Operation
- Internal registers: state {SEARCH, ACQUIRE, LOCKED}, last[WIDTH], run[3:0], miss[3:0].
- Samples with in_valid=0 are ignored: no register changes, and err_pulse is 0 in the following cycle.
- pred = (last + STEP) mod 2^WIDTH. Carry out is discarded, so 255 + 2 = 1 at WIDTH=8.
- SEARCH:
  - Valid sample with LSB=1: last<=in_data, run<=1, go to ACQUIRE.
  - Valid sample with LSB=0: stay in SEARCH and count no error.
- ACQUIRE:
  - in_data==pred: last<=in_data, run<=run+1. If run+1==LOCK_CNT, go to LOCKED with miss<=0.
  - Mismatch with odd in_data: restart; last<=in_data, run<=1, stay in ACQUIRE.
  - Mismatch with even in_data: go to SEARCH.
  - No errors are counted in ACQUIRE.
- LOCKED:
  - in_data==pred: last<=in_data, miss<=0.
  - Mismatch: err_pulse<=1 and err_count<=err_count+1 (saturating).
    - Freewheel: last<=pred, so a single corrupt sample does not cause a cascade of errors.
    - miss<=miss+1. If miss+1==LOSS_CNT, go to SEARCH and clear run and miss.
- Lock loss does not clear err_count; only reset clears it.
- expected is driven combinationally from last (expected = pred).

## Timing
- Reset values:
  - state=SEARCH, last=0, run=0, miss=0.
  - locked=0, err_pulse=0, err_count=0, expected=STEP.
- Reset mid-operation takes priority over in_valid in the same cycle. All state returns to its reset value on the next edge.
- locked, err_pulse and err_count are registered. Each reflects the sample accepted on the previous edge (latency 1).
- Lock asserts 1 cycle after the LOCK_CNT-th consecutive good sample. At least LOCK_CNT valid samples are needed after reset.
- Lock deasserts 1 cycle after the LOSS_CNT-th consecutive mismatch. That final mismatch still pulses err_pulse and increments err_count.
- A sample can be accepted every cycle; there is no backpressure. Gaps in in_valid do not break run or miss counts.
- err_count at all-ones: it holds at all-ones, and err_pulse still pulses.
- The upstream counter outputs 0 during reset, and its first sample after reset may repeat a value. SEARCH/ACQUIRE absorb both without counting errors.

## Test plan
- Lock acquisition: reset, then valid 1,3,5 on consecutive cycles -> locked=1 in the cycle after 5; err_count=0; expected=7.
- Wrap-around: locked stream …,251,253,255,1,3 -> no err_pulse; locked stays 1; expected=5 after 3.
- Single glitch: locked, expected 21; feed 21,40,25,27 -> one err_pulse in the cycle after 40; err_count=1; locked stays 1; expected=29.
- Lock loss (LOSS_CNT=2): locked, expected 9; feed 100,100 -> two err_pulses; locked=0 the cycle after the second 100; err_count=2; then 7,9,11 re-locks.
- Acquire restart/even reject: from reset feed 0,2,5,9,11,13 -> 0 and 2 ignored; 9 restarts acquisition; locked=1 after 13; err_count=0.
- Mid-run reset and gaps: locked with in_valid toggling 1/0, then assert reset for 1 cycle together with in_valid=1 and in_data=3 -> next cycle locked=0, err_count=0, expected=2; the held sample is discarded.
